rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 45 ++++
 rtl/rom_region_decode.sv | 38 +++
 rtl/rom_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared types and per-game ROM region maps for rom_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int MAX_REGIONS = 8;
    localparam int NUM_GAMES   = 2;
    localparam int ADDR_W      = 25;

    typedef logic [ADDR_W-1:0] addr_t;

    // Region maps indexed [game][region]; a zero size marks an unused slot.
    localparam addr_t REGION_BASE [NUM_GAMES][MAX_REGIONS] = '{
        '{25'h000_0000, 25'h000_4000, 25'h000_8000, 25'h000_C000,
          25'h000_0000, 25'h000_0000, 25'h000_0000, 25'h000_0000},
        '{25'h000_0000, 25'h001_0000, 25'h002_0000, 25'h003_0000,
          25'h004_0000, 25'h005_0000, 25'h006_0000, 25'h007_0000}
    };

    localparam addr_t REGION_SIZE [NUM_GAMES][MAX_REGIONS] = '{
        '{25'h000_4000, 25'h000_2000, 25'h000_4000, 25'h000_4000,
          25'h000_0000, 25'h000_0000, 25'h000_0000, 25'h000_0000},
        '{25'h001_0000, 25'h001_0000, 25'h001_0000, 25'h001_0000,
          25'h001_0000, 25'h001_0000, 25'h001_0000, 25'h001_0000}
    };

    // Range test written as (addr-base) < size so base+size never overflows.
    function automatic logic addr_in_region(input addr_t addr, input addr_t base,
                                            input addr_t size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rom_region_decode
//  Description : Combinational byte-address to region decoder. Returns a
//                one-hot hit vector (lowest matching region wins) and the
//                byte offset from that region's base.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int GAME        = 0
)(
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [NUM_REGIONS-1:0] o_hit,
    output logic [ADDR_W-1:0]      o_offset
);

    logic w_found;

    // Priority search: the first region containing the address claims it
    always_comb begin
        o_hit    = '0;
        o_offset = '0;
        w_found  = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (!w_found && addr_in_region(i_addr, REGION_BASE[GAME][r],
                                           REGION_SIZE[GAME][r])) begin
                o_hit[r] = 1'b1;
                o_offset = i_addr - REGION_BASE[GAME][r];
                w_found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Routes an ioctl byte download into per-region ROM write
//                strobes (8-bit or little-endian 16-bit words), holds the
//                game core in reset during and shortly after the load.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int DATA_W      = 8,
    parameter int DL_INDEX    = 0,
    parameter int HOLD_CYCLES = 16,
    parameter int GAME        = 0
)(
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [NUM_REGIONS-1:0] dn_wr,
    output logic [24:0]            dn_addr,
    output logic [DATA_W-1:0]      dn_data,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_err,
    output logic [24:0]            byte_count
);

    localparam int         c_addr_shift = DATA_W / 16;
    localparam logic [7:0] c_dl_index   = 8'(DL_INDEX);
    localparam logic [7:0] c_hold_last  = 8'(HOLD_CYCLES - 1);

    state_t                   r_state;
    logic [NUM_REGIONS-1:0]   r_dn_wr;
    logic [24:0]              r_dn_addr;
    logic [DATA_W-1:0]        r_dn_data;
    logic                     r_core_reset;
    logic                     r_load_done;
    logic                     r_load_err;
    logic [24:0]              r_byte_count;
    logic [7:0]               r_hold_cnt;
    logic                     r_pend;
    logic [7:0]               r_pend_lo;
    logic [NUM_REGIONS-1:0]   r_pend_hit;
    logic [24:0]              r_pend_addr;

    logic [NUM_REGIONS-1:0]   w_hit;
    logic [24:0]              w_offset;
    logic [24:0]              w_dn_addr;
    logic                     w_in_range;
    logic                     w_dl_start;
    logic                     w_accept;
    logic [DATA_W-1:0]        w_data_pair;
    logic [DATA_W-1:0]        w_data_odd_only;
    logic [DATA_W-1:0]        w_data_flush;

    rom_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .GAME        (GAME)
    ) u_decode (
        .i_addr   (ioctl_addr),
        .o_hit    (w_hit),
        .o_offset (w_offset)
    );

    assign w_in_range = |w_hit;
    assign w_dn_addr  = w_offset >> c_addr_shift;
    assign w_dl_start = ioctl_download && (ioctl_index == c_dl_index);
    // A strobe with a foreign index never belongs to our download.
    // ioctl_download is not required here: a byte coincident with the
    // falling edge of the download is still taken.
    assign w_accept   = ioctl_wr && (ioctl_index == c_dl_index);

    // Write-data formatting for the configured output width
    generate
        if (DATA_W == 16) begin : g_data16
            assign w_data_pair     = {ioctl_dout, r_pend_lo};
            assign w_data_odd_only = {ioctl_dout, 8'h00};
            assign w_data_flush    = {8'h00, r_pend_lo};
        end else begin : g_data8
            assign w_data_pair     = ioctl_dout;
            assign w_data_odd_only = ioctl_dout;
            assign w_data_flush    = r_pend_lo;
        end
    endgenerate

    // Loader sequencer with registered write port and status outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_dn_wr      <= '0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_byte_count <= '0;
            r_hold_cnt   <= '0;
            r_pend       <= 1'b0;
            r_pend_lo    <= '0;
            r_pend_hit   <= '0;
            r_pend_addr  <= '0;
        end else begin
            r_dn_wr <= '0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    // Bytes in the start cycle are not taken; the loader
                    // only presents data once the download is under way.
                    if (w_dl_start) begin
                        r_state      <= ST_LOAD;
                        r_core_reset <= 1'b1;
                        r_load_done  <= 1'b0;
                        r_load_err   <= 1'b0;
                        r_byte_count <= '0;
                        r_pend       <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_byte_count != '1) begin
                            r_byte_count <= r_byte_count + 1'b1;
                        end
                        if (!w_in_range) begin
                            r_load_err <= 1'b1;
                        end else if (DATA_W == 8) begin
                            r_dn_wr   <= w_hit;
                            r_dn_addr <= w_dn_addr;
                            r_dn_data <= w_data_pair;
                        end else if (!ioctl_addr[0]) begin
                            // A second even byte means the previous word
                            // never got its high half: emit it zero-padded.
                            if (r_pend) begin
                                r_dn_wr   <= r_pend_hit;
                                r_dn_addr <= r_pend_addr;
                                r_dn_data <= w_data_flush;
                            end
                            r_pend      <= 1'b1;
                            r_pend_lo   <= ioctl_dout;
                            r_pend_hit  <= w_hit;
                            r_pend_addr <= w_dn_addr;
                        end else begin
                            r_dn_wr   <= w_hit;
                            r_dn_addr <= w_dn_addr;
                            r_dn_data <= r_pend ? w_data_pair : w_data_odd_only;
                            r_pend    <= 1'b0;
                        end
                    end else if (!ioctl_download && r_pend) begin
                        r_dn_wr   <= r_pend_hit;
                        r_dn_addr <= r_pend_addr;
                        r_dn_data <= w_data_flush;
                        r_pend    <= 1'b0;
                    end
                    if (!ioctl_download) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end

                ST_HOLD: begin
                    // Catches an even byte that arrived with the falling edge
                    if (r_pend) begin
                        r_dn_wr   <= r_pend_hit;
                        r_dn_addr <= r_pend_addr;
                        r_dn_data <= w_data_flush;
                        r_pend    <= 1'b0;
                    end
                    if (r_hold_cnt == c_hold_last) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                        r_load_done  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dn_wr      = r_dn_wr;
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign byte_count = r_byte_count;

endmodule
`default_nettype wire
